// File: rtl/prog_clock_divider_if.sv
// Bus bundle for prog_clock_divider: run enables, half-period write port and
// the per-channel clock / strobe / pending outputs.
// Optional feature macro: CLKDIV_SYNC_EN adds the 1-bit "sync" restart input.
// NCH and CW must match the parameters of the prog_clock_divider instance.
interface prog_clock_divider_if #(
    parameter int NCH = 4,
    parameter int CW  = 25
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] en;
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_hp;
`ifdef CLKDIV_SYNC_EN
    logic           sync;
`endif
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] pend;

    // Controller side: drives enables and writes, observes the divided clocks.
    modport master (
        output en, wr_en, wr_ch, wr_hp,
`ifdef CLKDIV_SYNC_EN
        output sync,
`endif
        input  clk_out, rise, pend
    );

    // Divider side.
    modport slave (
        input  en, wr_en, wr_ch, wr_hp,
`ifdef CLKDIV_SYNC_EN
        input  sync,
`endif
        output clk_out, rise, pend
    );
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider. Each channel divides clk_in by
// 2*hp, giving a 50% duty clk_out and a one-cycle rise strobe. Half-period
// writes to a running channel are held in a shadow register and take effect
// only at terminal count, so a half-period is never cut short.
// Optional feature macro: CLKDIV_SYNC_EN (phase-aligned restart of all
// channels through bus.sync).

// One divider channel.
module prog_clock_divider_ch #(
    parameter int CW     = 25,
    parameter int DEF_HP = 25000000
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          en,
    input  logic          wr_hit,
    input  logic [CW-1:0] wr_val,
`ifdef CLKDIV_SYNC_EN
    input  logic          sync,
`endif
    output logic          clk_out,
    output logic          rise,
    output logic          pend
);
    logic [CW-1:0] cnt;
    logic [CW-1:0] hp;
    logic [CW-1:0] shadow;
    logic          tc;

    // hp is never 0 (writes of 0 are stored as 1), so hp-1 never wraps.
    assign tc = (cnt == hp - CW'(1));

    // Counter, output toggle and half-period update; sync > disable > TC > count.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            hp      <= CW'(DEF_HP);
            shadow  <= '0;
            clk_out <= 1'b0;
            rise    <= 1'b0;
            pend    <= 1'b0;
        end else begin
`ifdef CLKDIV_SYNC_EN
            if (sync) begin
                // Restart from phase zero; any pending value is applied now.
                cnt     <= '0;
                clk_out <= 1'b0;
                rise    <= 1'b0;
                pend    <= 1'b0;
                if (wr_hit)
                    hp <= wr_val;
                else if (pend)
                    hp <= shadow;
            end else
`endif
            if (!en) begin
                // Idle: hold low, keep hp/shadow; a write goes straight to hp.
                cnt     <= '0;
                clk_out <= 1'b0;
                rise    <= 1'b0;
                if (wr_hit) begin
                    hp   <= wr_val;
                    pend <= 1'b0;
                end
            end else if (tc) begin
                // End of half-period: toggle and pick the next half-period.
                cnt     <= '0;
                clk_out <= ~clk_out;
                rise    <= ~clk_out;
                pend    <= 1'b0;
                if (wr_hit)
                    hp <= wr_val;
                else if (pend)
                    hp <= shadow;
            end else begin
                // Mid half-period: a write is parked in the shadow.
                cnt  <= cnt + CW'(1);
                rise <= 1'b0;
                if (wr_hit) begin
                    shadow <= wr_val;
                    pend   <= 1'b1;
                end
            end
        end
    end
endmodule

module prog_clock_divider #(
    parameter int NCH    = 4,
    parameter int CW     = 25,
    parameter int DEF_HP = 25000000
) (
    input  logic                clk_in,
    input  logic                rst_n,
    prog_clock_divider_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef struct packed {
        logic           vld;
        logic [CHW-1:0] ch;
        logic [CW-1:0]  hp;
    } wr_req_t;

    wr_req_t       wr_req;
    logic [CW-1:0] wr_val;

    assign wr_req = '{vld: bus.wr_en, ch: bus.wr_ch, hp: bus.wr_hp};
    // A half-period of 0 is meaningless; treat it as divide-by-2.
    assign wr_val = (wr_req.hp == '0) ? CW'(1) : wr_req.hp;

    // Channel array; a channel index >= NCH matches no channel and is dropped.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic wr_hit;
        assign wr_hit = wr_req.vld && (wr_req.ch == CHW'(g));

        prog_clock_divider_ch #(
            .CW     (CW),
            .DEF_HP (DEF_HP)
        ) u_ch (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .en      (bus.en[g]),
            .wr_hit  (wr_hit),
            .wr_val  (wr_val),
`ifdef CLKDIV_SYNC_EN
            .sync    (bus.sync),
`endif
            .clk_out (bus.clk_out[g]),
            .rise    (bus.rise[g]),
            .pend    (bus.pend[g])
        );
    end
endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider (NCH=2, CW=8, DEF_HP=3).
// Stimulus pushes the reference model's prediction for every clock edge; the
// monitor pops and compares after each edge. The model tracks each channel as
// "cycles left in the current half-period" rather than an up-counter.
module tb_prog_clock_divider;
    localparam int NCH    = 2;
    localparam int CW     = 8;
    localparam int DEF_HP = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    prog_clock_divider_if #(.NCH(NCH), .CW(CW)) bus ();

    prog_clock_divider #(.NCH(NCH), .CW(CW), .DEF_HP(DEF_HP)) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [NCH-1:0] clk_o;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] pend;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state per channel.
    int m_hp[NCH], m_sh[NCH], m_left[NCH];
    bit m_pend[NCH], m_lvl[NCH], m_rise[NCH], m_run[NCH];

    // Rise-cycle log for the first free-running phase.
    bit log_rise = 1'b0;
    int log_cnt  = 0;
    int rise0_at[$];

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_hp[c] = DEF_HP; m_sh[c] = 0; m_left[c] = 0;
            m_pend[c] = 0; m_lvl[c] = 0; m_rise[c] = 0; m_run[c] = 0;
        end
    endfunction

    // Advance the model by one clk_in edge using the inputs currently driven.
    function automatic void model_step();
        int v;
        bit hit;
        v = (bus.wr_hp == '0) ? 1 : int'(bus.wr_hp);
        for (int c = 0; c < NCH; c++) begin
            hit = bus.wr_en && (int'(bus.wr_ch) == c);
`ifdef CLKDIV_SYNC_EN
            if (bus.sync) begin
                m_run[c] = 0; m_lvl[c] = 0; m_rise[c] = 0;
                m_hp[c] = hit ? v : (m_pend[c] ? m_sh[c] : m_hp[c]);
                m_pend[c] = 0;
                continue;
            end
`endif
            if (!bus.en[c]) begin
                m_run[c] = 0; m_lvl[c] = 0; m_rise[c] = 0;
                if (hit) begin m_hp[c] = v; m_pend[c] = 0; end
            end else begin
                if (!m_run[c]) begin m_run[c] = 1; m_left[c] = m_hp[c]; end
                m_left[c]--;
                m_rise[c] = 0;
                if (m_left[c] == 0) begin
                    m_rise[c] = !m_lvl[c];
                    m_lvl[c]  = !m_lvl[c];
                    m_hp[c]   = hit ? v : (m_pend[c] ? m_sh[c] : m_hp[c]);
                    m_pend[c] = 0;
                    m_left[c] = m_hp[c];
                end else if (hit) begin
                    m_sh[c] = v; m_pend[c] = 1;
                end
            end
        end
    endfunction

    // One cycle of stimulus: drive at negedge, predict, push expectation.
    task automatic step(input logic [NCH-1:0] e, input logic we, input logic ch,
                        input int hp, input logic sy);
        exp_t x;
        @(negedge clk);
        bus.en    = e;
        bus.wr_en = we;
        bus.wr_ch = ch;
        bus.wr_hp = hp[CW-1:0];
`ifdef CLKDIV_SYNC_EN
        bus.sync  = sy;
`else
        if (sy) $display("note: sync requested without CLKDIV_SYNC_EN");
`endif
        model_step();
        for (int c = 0; c < NCH; c++) begin
            x.clk_o[c] = m_lvl[c];
            x.rise[c]  = m_rise[c];
            x.pend[c]  = m_pend[c];
        end
        sb.push_back(x);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every edge that has a prediction queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (bus.clk_out !== e.clk_o || bus.rise !== e.rise || bus.pend !== e.pend) begin
                    bad++;
                    $display("FAIL out @%0t: got clk=%b rise=%b pend=%b want clk=%b rise=%b pend=%b",
                             $time, bus.clk_out, bus.rise, bus.pend, e.clk_o, e.rise, e.pend);
                end
                if (log_rise) begin
                    log_cnt++;
                    if (bus.rise[0]) rise0_at.push_back(log_cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        bus.en = '0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_hp = '0;
`ifdef CLKDIV_SYNC_EN
        bus.sync = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({bus.clk_out, bus.rise, bus.pend}), 0);
        rst_n = 1'b1;

        // Free run at default hp=3: ch0 rises on cycles 3, 9, 15.
        log_rise = 1'b1;
        repeat (18) step(2'b11, 0, 0, 0, 0);
        settle();
        log_rise = 1'b0;
        chk("rise0_count", rise0_at.size(), 3);
        for (int i = 0; i < 3 && i < rise0_at.size(); i++)
            chk("rise0_cycle", rise0_at[i], 3 + 6 * i);

        // Write 5 with cnt=0: pending until the current 3-cycle half-period ends.
        step(2'b11, 1, 0, 5, 0);
        settle();
        chk("pend0_set", int'(bus.pend[0]), 1);
        step(2'b11, 0, 0, 0, 0);
        step(2'b11, 0, 0, 0, 0);
        settle();
        chk("pend0_applied", int'(bus.pend[0]), 0);
        chk("clk0_high", int'(bus.clk_out[0]), 1);

        // Shadow 7, then overwrite with 2 exactly on the terminal-count cycle.
        step(2'b11, 1, 0, 7, 0);
        guard = 0;
        while (m_left[0] != 1 && guard < 20) begin
            step(2'b11, 0, 0, 0, 0);
            guard++;
        end
        chk("tc_reached", int'(guard < 20), 1);
        step(2'b11, 1, 0, 2, 0);
        settle();
        chk("tc_write_pend", int'(bus.pend[0]), 0);
        chk("tc_write_hp", m_hp[0], 2);
        repeat (12) step(2'b11, 0, 0, 0, 0);

        // Drop en[1] mid half-period, then re-enable.
        step(2'b11, 0, 0, 0, 0);
        step(2'b01, 0, 0, 0, 0);
        settle();
        chk("dis1_clk", int'(bus.clk_out[1]), 0);
        repeat (2) step(2'b01, 0, 0, 0, 0);
        repeat (10) step(2'b11, 0, 0, 0, 0);

        // Half-period 0 on ch1 is divide-by-2. (Channel select is one bit for
        // two channels, so no out-of-range index exists in this build.)
        step(2'b11, 1, 1, 0, 0);
        repeat (8) step(2'b11, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        #2;
        bus.en = '0; bus.wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", int'({bus.clk_out, bus.rise, bus.pend}), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) step(2'b11, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [NCH-1:0] e;
            for (int c = 0; c < NCH; c++) e[c] = ($urandom_range(7) != 0);
            step(e, ($urandom_range(3) == 0), 1'($urandom_range(1)),
                 int'($urandom_range(6)), ($urandom_range(49) == 0));
        end

`ifdef CLKDIV_SYNC_EN
        // Phase-aligned restart with ch0 hp=3 and ch1 hp=4.
        step(2'b00, 1, 0, 3, 0);
        step(2'b00, 1, 1, 4, 0);
        repeat (5) step(2'b11, 0, 0, 0, 0);
        step(2'b11, 0, 0, 0, 1);
        settle();
        chk("sync_clk", int'(bus.clk_out), 0);
        repeat (12) step(2'b11, 0, 0, 0, 0);
`endif

        settle();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
